// File: rtl/keccak_chi_pipe.sv
// Purpose: pipelined d-th order masked Keccak chi over ROWS 5-bit rows per beat.
// Latency: 2 cycles from accept to out_valid; 1 beat/cycle sustained with out_ready high.
// Backpressure: valid/ready on both ends; a stalled stage holds bit-exact, in_ready drops once both stages are full.
//
// Ports:
//   clk, rst_i            clock and synchronous active-high reset
//   in_valid/in_ready     input beat handshake; in_data carries ROWS*5 bits x (D+1) shares
//   rnd_valid/rnd_ready   fresh mask handshake; rnd_ready pulses only on a real accept
//   out_valid/out_ready   output beat handshake; out_data same layout as in_data
//   out_last              beat closes a 5-row plane
module keccak_chi_pipe #(
   parameter int D    = 2,
   parameter int ROWS = 1
) (
   input  logic                          clk,
   input  logic                          rst_i,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ROWS*5*(D+1)-1:0]       in_data,
   input  logic                          rnd_valid,
   output logic                          rnd_ready,
   input  logic [ROWS*5*D*(D+1)/2-1:0]   rnd,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ROWS*5*(D+1)-1:0]       out_data,
   output logic                          out_last
);

   localparam int SH          = D + 1;
   localparam int BW          = ROWS * 5 * SH;
   localparam int TW          = BW * SH;
   localparam int MPB         = D * SH / 2;   // masks per lane bit
   localparam int MPR         = 5 * MPB;      // masks per row
   localparam int PLANE_BEATS = 5 / ROWS;
   localparam logic [2:0] LAST_CNT = 3'(PLANE_BEATS - 1);

   if (ROWS != 1 && ROWS != 5) begin : g_bad_rows
      $error("keccak_chi_pipe: ROWS must be 1 or 5");
   end

   logic           rst_q;
   logic           s1_valid, s2_valid;
   logic           acc, s1_adv;
   logic [TW-1:0]  terms_d, terms_q;
   logic [BW-1:0]  out_d, out_q;
   logic [2:0]     cnt, s1_cnt, s2_cnt;

   assign s1_adv    = s1_valid & (~s2_valid | out_ready);
   // rst_q keeps the input closed for the first cycle after reset releases.
   assign in_ready  = ~rst_i & ~rst_q & (~s1_valid | s1_adv);
   assign acc       = in_valid & rnd_valid & in_ready;
   assign rnd_ready = acc;
   assign out_valid = s2_valid & ~rst_i;
   assign out_last  = out_valid & (s2_cnt == LAST_CNT);
   assign out_data  = out_q;

   // Symmetric mask index for share pair (i,j) of lane bit k; diagonal terms are unmasked.
   function automatic int mask_idx(int k, int i, int j);
      int mn;
      int mx;
      mn = (i < j) ? i : j;
      mx = (i < j) ? j : i;
      if (i == j) return 0;
      return k * MPB + mn + mx * (mx - 1) / 2;
   endfunction

   // Stage 1: cross-share products. Inverting share 0 of x_{k+1} inverts its unmasked value,
   // giving ~x_{k+1}; x_k enters only on the diagonal so each output share gets it once.
   always_comb begin
      terms_d = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < SH; i++) begin
               for (int j = 0; j < SH; j++) begin
                  terms_d[((r*5+k)*SH+i)*SH+j] =
                     ((in_data[(r*5+(k+1)%5)*SH+i] ^ (i == 0)) & in_data[(r*5+(k+2)%5)*SH+j]) ^
                     ((i == j) ? in_data[(r*5+k)*SH+i] : rnd[r*MPR + mask_idx(k, i, j)]);
               end
            end
         end
      end
   end

   // Stage 2: compress registered terms; masks cancel pairwise across output shares.
   always_comb begin
      out_d = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < SH; i++) begin
               out_d[(r*5+k)*SH+i] = ^terms_q[((r*5+k)*SH+i)*SH +: SH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      rst_q <= rst_i;
      if (rst_i) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         terms_q  <= '0;
         out_q    <= '0;
         cnt      <= '0;
         s1_cnt   <= '0;
         s2_cnt   <= '0;
      end else begin
         if (acc) begin
            s1_valid <= 1'b1;
            terms_q  <= terms_d;
            s1_cnt   <= cnt;
            cnt      <= (cnt == LAST_CNT) ? 3'd0 : cnt + 3'd1;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         if (s1_adv) begin
            s2_valid <= 1'b1;
            out_q    <= out_d;
            s2_cnt   <= s1_cnt;
         end else if (out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keccak_chi_pipe.sv
// Self-checking bench for keccak_chi_pipe (D=2): one ROWS=1 instance driven by directed
// phases plus a random phase, and one ROWS=5 instance streaming randomly in the background.
module tb_keccak_chi_pipe;

   localparam int D  = 2;
   localparam int SH = D + 1;
   localparam int W1 = 5 * SH;
   localparam int R1 = 5 * D * SH / 2;
   localparam int W5 = 25 * SH;
   localparam int R5 = 5 * R1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_i;
   logic iv1, ir1, rv1, rr1, ov1, or1, ol1;
   logic [W1-1:0] id1, od1;
   logic [R1-1:0] rn1;
   logic iv5, ir5, rv5, rr5, ov5, or5, ol5;
   logic [W5-1:0] id5, od5;
   logic [R5-1:0] rn5;

   keccak_chi_pipe #(.D(D), .ROWS(1)) dut1 (
      .clk(clk), .rst_i(rst_i),
      .in_valid(iv1), .in_ready(ir1), .in_data(id1),
      .rnd_valid(rv1), .rnd_ready(rr1), .rnd(rn1),
      .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_last(ol1));

   keccak_chi_pipe #(.D(D), .ROWS(5)) dut5 (
      .clk(clk), .rst_i(rst_i),
      .in_valid(iv5), .in_ready(ir5), .in_data(id5),
      .rnd_valid(rv5), .rnd_ready(rr5), .rnd(rn5),
      .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_last(ol5));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [4:0] chi_row(input logic [4:0] x);
      logic [4:0] y;
      y = '0;
      for (int k = 0; k < 5; k++) y[k] = x[k] ^ (~x[(k+1)%5] & x[(k+2)%5]);
      return y;
   endfunction

   function automatic logic [24:0] chi_rows(input logic [24:0] x);
      logic [24:0] y;
      y = '0;
      for (int r = 0; r < 5; r++) y[r*5 +: 5] = chi_row(x[r*5 +: 5]);
      return y;
   endfunction

   function automatic logic [24:0] unmask(input logic [W5-1:0] d);
      logic [24:0] u;
      u = '0;
      for (int b = 0; b < 25; b++) u[b] = d[b*SH] ^ d[b*SH+1] ^ d[b*SH+2];
      return u;
   endfunction

   function automatic logic [W5-1:0] make_shares(input logic [24:0] v);
      logic [W5-1:0] d;
      logic a, c;
      d = '0;
      for (int b = 0; b < 25; b++) begin
         a = 1'($urandom);
         c = 1'($urandom);
         d[b*SH]   = v[b] ^ a ^ c;
         d[b*SH+1] = a;
         d[b*SH+2] = c;
      end
      return d;
   endfunction

   // ---------------- ROWS=1 monitor / scoreboard ----------------
   logic [5:0]  q1[$];           // {last, unmasked chi row}
   int          pcnt1 = 0;       // beats accepted in current plane
   int          n_acc1 = 0, n_pop1 = 0;
   int          acc_cyc1 = -10, pop_cyc1 = -10;
   int          acc_breaks1 = 0, pop_breaks1 = 0;
   logic [4:0]  last_val1;
   logic [31:0] last_hist1;
   logic        hold1 = 1'b0;
   logic [W1-1:0] hold_d1;
   logic        hold_l1;
   logic [5:0]  e1;

   always @(negedge clk) begin
      cyc++;
      if (rst_i) begin
         check("rst_out_valid", 32'(ov1), 0);
         check("rst_in_ready", 32'(ir1), 0);
         check("rst_rnd_ready", 32'(rr1), 0);
         q1.delete();
         pcnt1 = 0;
         hold1 = 1'b0;
      end else begin
         check("rnd_ready_is_accept", 32'(rr1), 32'(iv1 & rv1 & ir1));
         if (hold1) begin
            check("stall_valid_held", 32'(ov1), 1);
            check("stall_data_stable", 32'(unmask(W5'(od1 ^ hold_d1))), 0);
            check("stall_last_stable", 32'(ol1), 32'(hold_l1));
         end
         if (iv1 && rv1 && ir1) begin
            q1.push_back({pcnt1 == 4, chi_row(unmask(W5'(id1)) & 25'h1f)});
            pcnt1 = (pcnt1 + 1) % 5;
            if (cyc != acc_cyc1 + 1) acc_breaks1++;
            acc_cyc1 = cyc;
            n_acc1++;
         end
         if (ov1 && or1) begin
            if (q1.size() == 0) begin
               check("spurious_output", 1, 0);
            end else begin
               e1 = q1.pop_front();
               check("chi_data", 32'(unmask(W5'(od1))), 32'(e1[4:0]));
               check("out_last", 32'(ol1), 32'(e1[5]));
            end
            last_val1  = 5'(unmask(W5'(od1)));
            last_hist1 = {last_hist1[30:0], ol1};
            if (cyc != pop_cyc1 + 1) pop_breaks1++;
            pop_cyc1 = cyc;
            n_pop1++;
         end
         hold1   = ov1 & ~or1;
         hold_d1 = od1;
         hold_l1 = ol1;
      end
   end

   // ---------------- ROWS=5 background stream ----------------
   logic [24:0] q5[$];
   int          n_pop5 = 0;
   logic        done5 = 1'b0;
   logic [24:0] e5;

   always @(negedge clk) begin
      if (rst_i) begin
         q5.delete();
      end else begin
         check("r5_rnd_ready_is_accept", 32'(rr5), 32'(iv5 & rv5 & ir5));
         if (iv5 && rv5 && ir5) q5.push_back(chi_rows(unmask(id5)));
         if (ov5 && or5) begin
            if (q5.size() == 0) begin
               check("r5_spurious_output", 1, 0);
            end else begin
               e5 = q5.pop_front();
               check("r5_chi_data", 32'(unmask(od5)), 32'(e5));
               check("r5_out_last", 32'(ol5), 1);
            end
            n_pop5++;
         end
      end
   end

   initial begin
      iv5 = 1'b0; rv5 = 1'b0; or5 = 1'b0; id5 = '0; rn5 = '0;
      @(posedge clk); #1;
      while (!done5) begin
         id5 = make_shares(25'($urandom));
         rn5 = {$urandom, $urandom, $urandom};
         iv5 = 1'($urandom);
         rv5 = ($urandom_range(0, 3) != 0);
         or5 = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      iv5 = 1'b0; rv5 = 1'b0;
   end

   // ---------------- ROWS=1 driver tasks ----------------
   logic [W5-1:0] tmp;

   task automatic load1(input logic [4:0] v);
      tmp = make_shares(25'(v));
      id1 = tmp[W1-1:0];
      rn1 = R1'($urandom);
   endtask

   task automatic send1(input logic [4:0] v);
      bit ok;
      load1(v);
      iv1 = 1'b1;
      rv1 = 1'b1;
      ok  = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge clk);
         if (ir1) ok = 1'b1;
      end
      if (!ok) check("send_timeout", 1, 0);
      @(posedge clk); #1;
   endtask

   task automatic idle1();
      iv1 = 1'b0;
      rv1 = 1'b0;
   endtask

   task automatic drain1();
      bit ok;
      idle1();
      or1 = 1'b1;
      ok  = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge clk);
         if (q1.size() == 0 && !ov1) ok = 1'b1;
      end
      check("drain_empty", 32'(q1.size()), 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      idle1();
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
   endtask

   int base;

   initial begin
      rst_i = 1'b1;
      iv1 = 1'b0; rv1 = 1'b0; or1 = 1'b1; id1 = '0; rn1 = '0;
      last_hist1 = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;

      // reset state: first cycle after release still closed, then open
      @(negedge clk);
      check("reset_out_valid", 32'(ov1), 0);
      check("reset_out_last", 32'(ol1), 0);
      check("reset_out_data", 32'(od1), 0);
      check("reset_in_ready_first_cycle", 32'(ir1), 0);
      @(negedge clk);
      check("in_ready_after_reset", 32'(ir1), 1);
      @(posedge clk); #1;

      // T1: a=1 only -> a,d set; 2-cycle latency
      send1(5'h01);
      idle1();
      repeat (4) @(posedge clk); #1;
      check("t1_value", 32'(last_val1), 32'h09);
      check("t1_latency", 32'(pop_cyc1 - acc_cyc1), 2);
      send1(5'h02);
      idle1();
      repeat (4) @(posedge clk); #1;
      check("t1_value_b", 32'(last_val1), 32'h12);

      // T2: all 32 row values back-to-back, no bubbles
      base = n_pop1;
      acc_breaks1 = 0;
      pop_breaks1 = 0;
      for (int v = 0; v < 32; v++) send1(5'(v));
      drain1();
      check("t2_count", 32'(n_pop1 - base), 32);
      check("t2_accept_bubbles", 32'(acc_breaks1), 1);
      check("t2_output_bubbles", 32'(pop_breaks1), 1);

      // T3: output stall while streaming
      base = n_pop1;
      fork
         begin
            for (int n = 0; n < 12; n++) send1(5'($urandom));
            idle1();
         end
         begin
            repeat (3) @(posedge clk);
            #1 or1 = 1'b0;
            repeat (4) @(negedge clk);
            check("t3_in_ready_stalled", 32'(ir1), 0);
            check("t3_out_valid_held", 32'(ov1), 1);
            repeat (2) @(negedge clk);
            @(posedge clk);
            #1 or1 = 1'b1;
         end
      join
      drain1();
      check("t3_count", 32'(n_pop1 - base), 12);

      // T4: data without randomness is not accepted
      base = n_acc1;
      load1(5'h15);
      iv1 = 1'b1;
      rv1 = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("t4_rnd_ready_low", 32'(rr1), 0);
         @(posedge clk); #1;
      end
      check("t4_no_accept", 32'(n_acc1 - base), 0);
      rv1 = 1'b1;
      @(negedge clk);
      check("t4_accept_on_rnd", 32'(rr1), 1);
      @(posedge clk); #1;
      idle1();
      drain1();
      check("t4_one_accept", 32'(n_acc1 - base), 1);

      // T5: plane boundaries on beats 5 and 10 after a fresh reset
      do_reset();
      last_hist1 = '0;
      base = n_pop1;
      for (int n = 0; n < 12; n++) send1(5'($urandom));
      drain1();
      check("t5_count", 32'(n_pop1 - base), 12);
      check("t5_last_pattern", 32'(last_hist1[11:0]), 32'h084);

      // T6: reset with two beats in flight
      or1 = 1'b0;
      send1(5'h07);
      send1(5'h0b);
      idle1();
      @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("t6_out_valid_after_reset", 32'(ov1), 0);
      base = n_pop1;
      or1 = 1'b1;
      repeat (6) @(posedge clk); #1;
      check("t6_dropped", 32'(n_pop1 - base), 0);
      last_hist1 = '0;
      for (int n = 0; n < 5; n++) send1(5'($urandom));
      drain1();
      check("t6_plane_last", 32'(last_hist1[4:0]), 32'h01);

      // random traffic on the ROWS=1 instance
      for (int n = 0; n < 400; n++) begin
         load1(5'($urandom));
         iv1 = 1'($urandom);
         rv1 = ($urandom_range(0, 3) != 0);
         or1 = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      drain1();

      done5 = 1'b1;
      repeat (4) @(posedge clk); #1;
      check("r5_activity", 32'(n_pop5 > 20), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
